// File: rtl/ledr_pwm_dimmer.sv
// LEDR dimmer between the PIO out_port and the board pins: global PWM brightness plus optional blink.
// Define LEDR_PWM_GAMMA_EN to square the duty value on load, giving a perceptual brightness curve.
module ledr_pwm_dimmer #(
  parameter int N_LEDS     = 10,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALE   = 50,
  parameter int BLINK_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_in,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [N_LEDS-1:0] led_out
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam int WDATA_USED = (BLINK_BITS > PWM_BITS) ? BLINK_BITS : PWM_BITS;

  logic [PRESC_W-1:0]    presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [PWM_BITS-1:0]   duty_reg;
  logic [PWM_BITS-1:0]   duty_act;
  logic [PWM_BITS-1:0]   duty_next;
  logic [BLINK_BITS-1:0] period_reg;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic                  blink_phase;
  logic [N_LEDS-1:0]     led_q;
  logic                  tick;
  logic                  wrap;
  logic                  pwm_on;
  logic                  wr_en;
  logic                  wr_duty;
  logic                  wr_period;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata[31:WDATA_USED];

  assign wr_en     = chipselect & ~write_n;
  assign wr_duty   = wr_en & (address == 2'd0);
  assign wr_period = wr_en & (address == 2'd1);

  assign tick = (presc_cnt == PRESC_MAX);
  assign wrap = tick & (pwm_cnt == PWM_MAX);

`ifdef LEDR_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  logic                  unused_sq_lo;

  assign duty_sq      = {{PWM_BITS{1'b0}}, duty_reg} * {{PWM_BITS{1'b0}}, duty_reg};
  assign unused_sq_lo = ^duty_sq[PWM_BITS-1:0];
  assign duty_next    = (duty_reg == PWM_MAX) ? PWM_MAX : duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign duty_next = duty_reg;
`endif

  // All-ones is a dedicated full-on code so 100% brightness is reachable.
  always_comb begin
    if (duty_act == PWM_MAX)
      pwm_on = 1'b1;
    else if (duty_act == '0)
      pwm_on = 1'b0;
    else
      pwm_on = (pwm_cnt < duty_act);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick)
        pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // duty_act only follows duty_reg at a period boundary, so a write never truncates a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_reg   <= '1;
      duty_act   <= '1;
      period_reg <= '0;
    end else begin
      if (wrap)
        duty_act <= duty_next;
      if (wr_duty)
        duty_reg <= writedata[PWM_BITS-1:0];
      if (wr_period)
        period_reg <= writedata[BLINK_BITS-1:0];
    end
  end

  // A period write restarts the blink cycle in the visible phase, even on a wrap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr_period || (period_reg == '0)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wrap) begin
      if (blink_cnt == period_reg - 1'b1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= '0;
      led_out <= '0;
    end else begin
      led_q   <= led_in;
      led_out <= led_q & {N_LEDS{pwm_on & blink_phase}};
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[PWM_BITS-1:0]   = duty_reg;
      2'd1:    readdata[BLINK_BITS-1:0] = period_reg;
      2'd2:    readdata[PWM_BITS:0]     = {pwm_cnt, blink_phase};
      default: readdata = '0;
    endcase
  end

endmodule
